// File: rtl/traffic_light_controller_param.sv
// Parameterised N-way traffic light controller with a free-running one-second
// tick, per-phase BCD countdown and emergency pre-emption.
module traffic_light_controller_param #(
  parameter int unsigned N_DIR    = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GREEN_T  = 25,
  parameter int unsigned YELLOW_T = 5,
  parameter int unsigned CLEAR_T  = 2,
  localparam int unsigned DW      = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DIR-1:0]   req,
  input  logic               emerg,
  input  logic [DW-1:0]      emerg_dir,
  output logic [3*N_DIR-1:0] lights,
  output logic [DW-1:0]      active_dir,
  output logic [1:0]         phase,
  output logic [3:0]         cnt_tens,
  output logic [3:0]         cnt_ones,
  output logic               tick
);

  localparam int unsigned CW    = $clog2(TICK_DIV);
  localparam int unsigned CNT_W = 7;

  localparam logic [CNT_W-1:0]   GREEN_CNT  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0]   YELLOW_CNT = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0]   CLEAR_CNT  = CNT_W'(CLEAR_T);
  localparam logic [3*N_DIR-1:0] ALL_RED    = {N_DIR{3'b100}};

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_CLEAR  = 2'b10,
    PH_EMERG  = 2'b11
  } phase_e;

  phase_e             state_q, state_d;
  logic [DW-1:0]      dir_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CW-1:0]      tick_cnt;
  logic [DW-1:0]      edir_eff;
  logic [DW-1:0]      next_dir;
  logic               found;
  logic [3*N_DIR-1:0] lights_d;
  logic [3:0]         tens_d, ones_d;

  assign phase = state_q;

  // Out-of-range emergency directions fold to direction 0
  assign edir_eff = (32'(emerg_dir) < N_DIR) ? emerg_dir : '0;

  // Free-running tick divider; tick is high while the divider sits at TICK_DIV-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      if (tick_cnt == CW'(TICK_DIV - 1)) tick_cnt <= '0;
      else                               tick_cnt <= tick_cnt + CW'(1);
      tick <= (tick_cnt == CW'(TICK_DIV - 2));
    end
  end

  // Circular search for the next requesting direction after active_dir
  always_comb begin
    next_dir = DW'((32'(active_dir) + 32'd1) % N_DIR);
    found    = 1'b0;
    for (int unsigned k = 1; k <= N_DIR; k++) begin
      int unsigned idx;
      idx = (32'(active_dir) + k) % N_DIR;
      if (!found && ((req >> idx) & N_DIR'(1)) != '0) begin
        next_dir = DW'(idx);
        found    = 1'b1;
      end
    end
  end

  // Phase sequencing, countdown and emergency pre-emption
  always_comb begin
    state_d = state_q;
    dir_d   = active_dir;
    count_d = count_q;
    case (state_q)
      PH_GREEN: begin
        if (emerg) begin
          if (edir_eff == active_dir) begin
            state_d = PH_EMERG;
            count_d = '0;
          end else begin
            state_d = PH_YELLOW;
            count_d = YELLOW_CNT;
          end
        end else if (tick) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            state_d = PH_YELLOW;
            count_d = YELLOW_CNT;
          end
        end
      end
      PH_YELLOW: begin
        if (tick) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            state_d = PH_CLEAR;
            count_d = CLEAR_CNT;
          end
        end
      end
      PH_CLEAR: begin
        if (tick) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else if (emerg) begin
            state_d = PH_EMERG;
            dir_d   = edir_eff;
            count_d = '0;
          end else begin
            state_d = PH_GREEN;
            dir_d   = next_dir;
            count_d = GREEN_CNT;
          end
        end
      end
      PH_EMERG: begin
        if (!emerg) begin
          state_d = PH_YELLOW;
          count_d = YELLOW_CNT;
        end
      end
      default: begin
        state_d = PH_CLEAR;
        count_d = CLEAR_CNT;
      end
    endcase
  end

  // BCD digits of the upcoming countdown value
  assign tens_d = 4'(count_d / CNT_W'(10));
  assign ones_d = 4'(count_d % CNT_W'(10));

  // Per-direction lamp pattern for the upcoming phase
  for (genvar d = 0; d < N_DIR; d++) begin : g_lamp
    assign lights_d[3*d +: 3] = (state_d == PH_CLEAR || dir_d != DW'(d)) ? 3'b100 :
                                (state_d == PH_YELLOW)                    ? 3'b010 :
                                                                            3'b001;
  end

  // State register together with its registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PH_CLEAR;
      active_dir <= DW'(N_DIR - 1);
      count_q    <= CLEAR_CNT;
      cnt_tens   <= 4'(CLEAR_T / 10);
      cnt_ones   <= 4'(CLEAR_T % 10);
      lights     <= ALL_RED;
    end else begin
      state_q    <= state_d;
      active_dir <= dir_d;
      count_q    <= count_d;
      cnt_tens   <= tens_d;
      cnt_ones   <= ones_d;
      lights     <= lights_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Bench for traffic_light_controller_param: two instances (4-way fast timing,
// 2-way with a 25-tick green) checked every cycle against a behavioural model.
module tb_traffic_light_controller_param;

  localparam int NA = 4, TDA = 4, GTA = 3,  YTA = 2, CTA = 1;
  localparam int NB = 2, TDB = 2, GTB = 25, YTB = 2, CTB = 1;
  localparam int PH_G = 0, PH_Y = 1, PH_C = 2, PH_E = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [3:0]  req_a = '0;
  logic        emerg_a = 1'b0;
  logic [1:0]  edir_a = '0;
  logic [11:0] lights_a;
  logic [1:0]  dir_a;
  logic [1:0]  ph_a;
  logic [3:0]  tens_a, ones_a;
  logic        tick_a;

  logic [1:0]  req_b = '0;
  logic        emerg_b = 1'b0;
  logic [0:0]  edir_b = '0;
  logic [5:0]  lights_b;
  logic [0:0]  dir_b;
  logic [1:0]  ph_b;
  logic [3:0]  tens_b, ones_b;
  logic        tick_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    int ph;
    int dir;
    int cnt;
    int cyc;
  } mdl_t;

  mdl_t ma, mb;

  traffic_light_controller_param #(
    .N_DIR(NA), .TICK_DIV(TDA), .GREEN_T(GTA), .YELLOW_T(YTA), .CLEAR_T(CTA)
  ) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .emerg(emerg_a), .emerg_dir(edir_a),
    .lights(lights_a), .active_dir(dir_a), .phase(ph_a),
    .cnt_tens(tens_a), .cnt_ones(ones_a), .tick(tick_a)
  );

  traffic_light_controller_param #(
    .N_DIR(NB), .TICK_DIV(TDB), .GREEN_T(GTB), .YELLOW_T(YTB), .CLEAR_T(CTB)
  ) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .emerg(emerg_b), .emerg_dir(edir_b),
    .lights(lights_b), .active_dir(dir_b), .phase(ph_b),
    .cnt_tens(tens_b), .cnt_ones(ones_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset(int n, int ct);
    mdl_t r;
    r.ph  = PH_C;
    r.dir = n - 1;
    r.cnt = ct;
    r.cyc = 0;
    return r;
  endfunction

  // One clock of the traffic rules; cyc counts edges since reset release
  function automatic mdl_t mdl_step(mdl_t m, int n, int td, int gt, int yt, int ct,
                                    int req, bit em, int edir);
    mdl_t r;
    bit   tk;
    int   ed;
    int   nd;
    r     = m;
    tk    = (m.cyc % td) == td - 1;
    ed    = (edir >= n) ? 0 : edir;
    r.cyc = m.cyc + 1;
    nd    = (m.dir + 1) % n;
    for (int k = n; k >= 1; k--)
      if (((req >> ((m.dir + k) % n)) & 1) != 0) nd = (m.dir + k) % n;
    if (m.ph == PH_E) begin
      if (!em) begin r.ph = PH_Y; r.cnt = yt; end
    end else if (m.ph == PH_G && em) begin
      if (ed == m.dir) begin r.ph = PH_E; r.cnt = 0; end
      else begin r.ph = PH_Y; r.cnt = yt; end
    end else if (tk) begin
      if (m.cnt > 1)          r.cnt = m.cnt - 1;
      else if (m.ph == PH_G)  begin r.ph = PH_Y; r.cnt = yt; end
      else if (m.ph == PH_Y)  begin r.ph = PH_C; r.cnt = ct; end
      else if (em)            begin r.ph = PH_E; r.dir = ed; r.cnt = 0; end
      else                    begin r.ph = PH_G; r.dir = nd; r.cnt = gt; end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_lights(mdl_t m, int n);
    logic [31:0] v;
    logic [2:0]  l;
    v = '0;
    for (int d = 0; d < n; d++) begin
      if (m.ph == PH_C || d != m.dir) l = 3'b100;
      else if (m.ph == PH_Y)          l = 3'b010;
      else                            l = 3'b001;
      v[3*d +: 3] = l;
    end
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_phase",  32'(ph_a),     32'(ma.ph));
    chk("a_dir",    32'(dir_a),    32'(ma.dir));
    chk("a_tens",   32'(tens_a),   32'(ma.cnt / 10));
    chk("a_ones",   32'(ones_a),   32'(ma.cnt % 10));
    chk("a_lights", 32'(lights_a), exp_lights(ma, NA));
    chk("a_tick",   32'(tick_a),   32'((ma.cyc % TDA) == TDA - 1));
    chk("b_phase",  32'(ph_b),     32'(mb.ph));
    chk("b_dir",    32'(dir_b),    32'(mb.dir));
    chk("b_tens",   32'(tens_b),   32'(mb.cnt / 10));
    chk("b_ones",   32'(ones_b),   32'(mb.cnt % 10));
    chk("b_lights", 32'(lights_b), exp_lights(mb, NB));
    chk("b_tick",   32'(tick_b),   32'((mb.cyc % TDB) == TDB - 1));
  endtask

  // Advance one clock, step both models with the inputs seen at the edge, then compare
  task automatic cyc();
    @(posedge clk);
    if (!reset) begin
      ma = mdl_reset(NA, CTA);
      mb = mdl_reset(NB, CTB);
    end else begin
      ma = mdl_step(ma, NA, TDA, GTA, YTA, CTA, int'(req_a), emerg_a, int'(edir_a));
      mb = mdl_step(mb, NB, TDB, GTB, YTB, CTB, int'(req_b), emerg_b, int'(edir_b));
    end
    #1;
    check_all();
  endtask

  task automatic run_until_a(int ph, int dir, int bound, string tag);
    int k;
    bit hit;
    k = 0;
    while (!(ma.ph == ph && (dir < 0 || ma.dir == dir)) && k < bound) begin
      cyc();
      k++;
    end
    hit = (ma.ph == ph && (dir < 0 || ma.dir == dir));
    n_checks++;
    assert (hit) else begin
      n_errors++;
      $error("FAIL %s observed=timeout expected=reached within %0d cycles", tag, bound);
    end
  endtask

  task automatic run_until_b(int ph, int dir, int bound, string tag);
    int k;
    bit hit;
    k = 0;
    while (!(mb.ph == ph && (dir < 0 || mb.dir == dir)) && k < bound) begin
      cyc();
      k++;
    end
    hit = (mb.ph == ph && (dir < 0 || mb.dir == dir));
    n_checks++;
    assert (hit) else begin
      n_errors++;
      $error("FAIL %s observed=timeout expected=reached within %0d cycles", tag, bound);
    end
  endtask

  initial begin
    int seq_ph   [7] = '{0, 0, 0, 1, 1, 2, 0};
    int seq_dir  [7] = '{0, 0, 0, 0, 0, 0, 1};
    int seq_ones [7] = '{3, 2, 1, 2, 1, 1, 3};

    // Reset values
    ma = mdl_reset(NA, CTA);
    mb = mdl_reset(NB, CTB);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_phase",  32'(ph_a),     32'h2);
    chk("rst_dir",    32'(dir_a),    32'h3);
    chk("rst_ones",   32'(ones_a),   32'h1);
    chk("rst_lights", 32'(lights_a), 32'h924);
    #2 reset = 1'b1;

    // Basic cycle with no requests: dir0 G 3,2,1 / Y 2,1 / C 1 / dir1 G
    for (int i = 0; i < 7; i++) begin
      repeat (4) cyc();
      chk("seq_phase", 32'(ph_a),   32'(seq_ph[i]));
      chk("seq_dir",   32'(dir_a),  32'(seq_dir[i]));
      chk("seq_ones",  32'(ones_a), 32'(seq_ones[i]));
    end

    // Request-driven selection skips idle directions
    req_a = 4'b1000;
    run_until_a(PH_G, 3, 100, "to_dir3");
    chk("req_dir3", 32'(dir_a), 32'h3);
    req_a = 4'b0001;
    run_until_a(PH_G, 0, 100, "to_dir0");
    chk("req_dir0", 32'(dir_a), 32'h0);
    req_a = 4'b0000;

    // Emergency to another direction during green
    repeat (2) cyc();
    emerg_a = 1'b1;
    edir_a  = 2'd2;
    cyc();
    chk("em_y_phase", 32'(ph_a),   32'h1);
    chk("em_y_ones",  32'(ones_a), 32'h2);
    run_until_a(PH_C, -1, 20, "em_to_clear");
    run_until_a(PH_E, -1, 20, "em_to_emerg");
    chk("em_dir",    32'(dir_a),          32'h2);
    chk("em_lamp2",  32'(lights_a[8:6]),  32'h1);
    chk("em_ones",   32'(ones_a),         32'h0);
    edir_a = 2'd1;
    repeat (5) cyc();
    chk("em_hold_dir",   32'(dir_a), 32'h2);
    chk("em_hold_phase", 32'(ph_a),  32'h3);
    emerg_a = 1'b0;
    cyc();
    chk("em_exit_phase", 32'(ph_a),   32'h1);
    chk("em_exit_dir",   32'(dir_a),  32'h2);
    chk("em_exit_ones",  32'(ones_a), 32'h2);

    // Emergency to the direction already green
    run_until_a(PH_G, 3, 100, "to_dir3_b");
    cyc();
    emerg_a = 1'b1;
    edir_a  = 2'd3;
    cyc();
    chk("em_same_phase", 32'(ph_a),  32'h3);
    chk("em_same_dir",   32'(dir_a), 32'h3);
    emerg_a = 1'b0;
    cyc();

    // Asynchronous reset mid-yellow
    run_until_a(PH_Y, -1, 100, "to_yellow");
    cyc();
    #2 reset = 1'b0;
    #1;
    ma = mdl_reset(NA, CTA);
    mb = mdl_reset(NB, CTB);
    chk("arst_lights", 32'(lights_a), 32'h924);
    chk("arst_phase",  32'(ph_a),     32'h2);
    chk("arst_tens",   32'(tens_a),   32'h0);
    chk("arst_ones",   32'(ones_a),   32'h1);
    chk("arst_tick",   32'(tick_a),   32'h0);
    check_all();
    cyc();
    #2 reset = 1'b1;

    // Two-direction instance: 25-tick BCD display, alternation, emergency on own green
    repeat (2) cyc();
    chk("b_g_phase", 32'(ph_b),   32'h0);
    chk("b_g_dir",   32'(dir_b),  32'h0);
    chk("b_g_tens",  32'(tens_b), 32'h2);
    chk("b_g_ones",  32'(ones_b), 32'h5);
    repeat (32) cyc();
    chk("b_16_tens", 32'(tens_b), 32'h0);
    chk("b_16_ones", 32'(ones_b), 32'h9);
    run_until_b(PH_G, 1, 200, "b_to_dir1");
    chk("b_alt1", 32'(dir_b), 32'h1);
    cyc();
    emerg_b = 1'b1;
    edir_b  = 1'b1;
    cyc();
    chk("b_em_phase", 32'(ph_b),  32'h3);
    chk("b_em_dir",   32'(dir_b), 32'h1);
    emerg_b = 1'b0;
    cyc();
    chk("b_exit_phase", 32'(ph_b), 32'h1);
    run_until_b(PH_G, -1, 200, "b_next_green");
    chk("b_alt0", 32'(dir_b), 32'h0);
    cyc();
    run_until_b(PH_G, 1, 200, "b_to_dir1_again");
    chk("b_alt1_again", 32'(dir_b), 32'h1);

    // Randomised traffic and emergencies against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  req_a   = 4'($urandom);
      if ($urandom_range(0, 59) == 0) emerg_a = ~emerg_a;
      if ($urandom_range(0, 3) == 0)  edir_a  = 2'($urandom);
      if ($urandom_range(0, 7) == 0)  req_b   = 2'($urandom);
      if ($urandom_range(0, 89) == 0) emerg_b = ~emerg_b;
      if ($urandom_range(0, 3) == 0)  edir_b  = 1'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
